// File: rtl/booth_r4_mult_if.sv
// Operand/result bus of the radix-4 Booth multiplier.
// The master drives start and the operands; the slave (multiplier) returns status and product.
interface booth_r4_mult_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_r4_mult.sv
// Radix-4 (modified) Booth sequential multiplier, two multiplier bits retired per clock.
// Operands are extended by two bits so that one datapath serves both signed and unsigned mode.
module booth_r4_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    booth_r4_mult_if.slave bus
);
    localparam int unsigned EW = WIDTH + 2;
    localparam int unsigned AW = EW + 2;
    localparam int unsigned N  = EW / 2;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned LW = WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_load;
    logic                 w_calc;
    logic                 w_finish;

    logic [AW-1:0]        r_a;
    logic [EW-1:0]        r_q;
    logic                 r_qm1;
    logic [EW-1:0]        r_y;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;
    logic                 r_done;

    logic [AW-1:0]        w_y_ext;
    logic [AW-1:0]        w_addend;
    logic [AW-1:0]        w_sum;
    logic [AW-1:0]        w_a_nxt;
    logic [EW-1:0]        w_q_nxt;
    logic [EW-1:0]        w_y_load;
    logic [EW-1:0]        w_x_load;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_calc      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_calc = 1'b1;
                if (r_cnt == CW'(N - 1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand extension at capture time
    always_comb begin
        if (bus.signed_mode) begin
            w_y_load = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            w_x_load = {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier};
        end else begin
            w_y_load = {2'b00, bus.multiplicand};
            w_x_load = {2'b00, bus.multiplier};
        end
    end

    // Booth recoding of {Q[1],Q[0],q_m1} and one accumulate/shift step
    always_comb begin
        w_y_ext = {{2{r_y[EW-1]}}, r_y};
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = w_y_ext;
            3'b011:         w_addend = w_y_ext << 1;
            3'b100:         w_addend = ~(w_y_ext << 1) + AW'(1);
            3'b101, 3'b110: w_addend = ~w_y_ext + AW'(1);
            default:        w_addend = '0;
        endcase
        w_sum   = r_a + w_addend;
        w_a_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
        w_q_nxt = {w_sum[1:0], r_q[EW-1:2]};
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_y   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_a   <= '0;
            r_q   <= w_x_load;
            r_qm1 <= 1'b0;
            r_y   <= w_y_load;
            r_cnt <= '0;
        end else if (w_calc) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_qm1 <= r_q[1];
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Product is only updated on the completion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else if (w_finish) begin
            r_product <= {w_a_nxt[LW-1:0], w_q_nxt};
        end
    end

    // Status flags track the state the FSM is entering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_CALC);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed bench for booth_r4_mult at WIDTH=8: products, latency, handshake and reset.
module tb_booth_r4_mult;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    logic [15:0] last_prod;

    booth_r4_mult_if #(.WIDTH(WIDTH)) bus_if ();

    booth_r4_mult #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) at negedges until done is seen; returns number of busy cycles observed
    task automatic wait_done(input string tag, output int busy_cnt, output logic got);
        busy_cnt = 0;
        got      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.done) begin
                got = 1'b1;
                break;
            end
            if (bus_if.busy) busy_cnt++;
            @(negedge clk);
        end
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic sm, input logic [7:0] y,
                          input logic [7:0] x, input logic [15:0] exp);
        int   bc;
        logic got;
        @(negedge clk);
        bus_if.start        = 1'b1;
        bus_if.signed_mode  = sm;
        bus_if.multiplicand = y;
        bus_if.multiplier   = x;
        @(negedge clk);
        // Operand changes after capture must not matter
        bus_if.start        = 1'b0;
        bus_if.signed_mode  = ~sm;
        bus_if.multiplicand = ~y;
        bus_if.multiplier   = ~x;
        chk({tag, "_hold"}, 32'(bus_if.product), 32'(last_prod));
        wait_done(tag, bc, got);
        if (got) begin
            chk({tag, "_prod"}, 32'(bus_if.product), 32'(exp));
            chk({tag, "_calc_cycles"}, 32'(bc), 32'd5);
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
        end
        last_prod = exp;
    endtask

    initial begin
        int   bc;
        int   t0;
        int   t1;
        logic got;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus_if.start        = 1'b0;
        bus_if.signed_mode  = 1'b0;
        bus_if.multiplicand = '0;
        bus_if.multiplier   = '0;
        last_prod           = 16'h0000;
        #23;
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_prod", 32'(bus_if.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("s_7xm3",      1'b1, 8'h07, 8'hFD, 16'hFFEB);
        run_op("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        run_op("s_m128x127",  1'b1, 8'h80, 8'h7F, 16'hC080);
        run_op("u_255x255",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run_op("s_m1xm1",     1'b1, 8'hFF, 8'hFF, 16'h0001);
        run_op("s_127x127",   1'b1, 8'h7F, 8'h7F, 16'h3F01);
        run_op("u_170x85",    1'b0, 8'hAA, 8'h55, 16'h3872);
        run_op("u_128x2",     1'b0, 8'h80, 8'h02, 16'h0100);

        // Product stays put through IDLE
        repeat (4) @(negedge clk);
        chk("idle_hold", 32'(bus_if.product), 32'h0100);

        // Back-to-back with start held: 3*5, 0*0x55, -1*-1
        bus_if.start        = 1'b1;
        bus_if.signed_mode  = 1'b0;
        bus_if.multiplicand = 8'd3;
        bus_if.multiplier   = 8'd5;
        @(posedge clk); #1;
        bus_if.multiplicand = 8'h00;
        bus_if.multiplier   = 8'h55;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b1;
        wait_done("b2b_1", bc, got);
        t0 = cyc;
        chk("b2b_1_prod", 32'(bus_if.product), 32'h000F);
        @(posedge clk); #1;
        bus_if.signed_mode  = 1'b1;
        bus_if.multiplicand = 8'hFF;
        bus_if.multiplier   = 8'hFF;
        @(negedge clk);
        chk("b2b_2_busy", 32'(bus_if.busy), 32'd1);
        wait_done("b2b_2", bc, got);
        t1 = cyc;
        chk("b2b_2_prod", 32'(bus_if.product), 32'h0000);
        chk("b2b_2_period", 32'(t1 - t0), 32'd6);
        @(posedge clk); #1;
        bus_if.start        = 1'b0;
        bus_if.signed_mode  = 1'b0;
        bus_if.multiplicand = 8'h12;
        bus_if.multiplier   = 8'h34;
        @(negedge clk);
        wait_done("b2b_3", bc, got);
        t0 = cyc;
        chk("b2b_3_prod", 32'(bus_if.product), 32'h0001);
        chk("b2b_3_period", 32'(t0 - t1), 32'd6);
        last_prod = 16'h0001;

        // Asynchronous reset in the 3rd CALC cycle
        @(negedge clk);
        bus_if.start        = 1'b1;
        bus_if.signed_mode  = 1'b0;
        bus_if.multiplicand = 8'd100;
        bus_if.multiplier   = 8'd100;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus_if.busy), 32'd0);
        chk("arst_done", 32'(bus_if.done), 32'd0);
        chk("arst_prod", 32'(bus_if.product), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        last_prod = 16'h0000;
        run_op("u_12x10", 1'b0, 8'd12, 8'd10, 16'h0078);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
